// File: rtl/iob_ext_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : iob_ext_mem_arbiter_if
// Brief   : Requester and external-memory bundle of the two-requester arbiter.
// Rev     : 1.0
// ============================================================================
interface iob_ext_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  r0_valid_i;
  logic [ADDR_W-1:0]     r0_addr_i;
  logic [DATA_W-1:0]     r0_wdata_i;
  logic [DATA_W/8-1:0]   r0_wstrb_i;
  logic                  r0_ready_o;
  logic                  r0_rvalid_o;
  logic [DATA_W-1:0]     r0_rdata_o;

  logic                  r1_valid_i;
  logic [ADDR_W-1:0]     r1_addr_i;
  logic [DATA_W-1:0]     r1_wdata_i;
  logic [DATA_W/8-1:0]   r1_wstrb_i;
  logic                  r1_ready_o;
  logic                  r1_rvalid_o;
  logic [DATA_W-1:0]     r1_rdata_o;

  logic                  ext_mem_r_en_o;
  logic [ADDR_W-1:0]     ext_mem_r_addr_o;
  logic [DATA_W-1:0]     ext_mem_r_data_i;
  logic [DATA_W/8-1:0]   ext_mem_w_strb_o;
  logic [ADDR_W-1:0]     ext_mem_w_addr_o;
  logic [DATA_W-1:0]     ext_mem_w_data_o;

  modport slave (
    input  r0_valid_i, r0_addr_i, r0_wdata_i, r0_wstrb_i,
    output r0_ready_o, r0_rvalid_o, r0_rdata_o,
    input  r1_valid_i, r1_addr_i, r1_wdata_i, r1_wstrb_i,
    output r1_ready_o, r1_rvalid_o, r1_rdata_o,
    output ext_mem_r_en_o, ext_mem_r_addr_o,
    input  ext_mem_r_data_i,
    output ext_mem_w_strb_o, ext_mem_w_addr_o, ext_mem_w_data_o
  );

  modport master (
    output r0_valid_i, r0_addr_i, r0_wdata_i, r0_wstrb_i,
    input  r0_ready_o, r0_rvalid_o, r0_rdata_o,
    output r1_valid_i, r1_addr_i, r1_wdata_i, r1_wstrb_i,
    input  r1_ready_o, r1_rvalid_o, r1_rdata_o,
    input  ext_mem_r_en_o, ext_mem_r_addr_o,
    output ext_mem_r_data_i,
    input  ext_mem_w_strb_o, ext_mem_w_addr_o, ext_mem_w_data_o
  );
endinterface
`default_nettype wire

// File: rtl/iob_ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : iob_ext_mem_arbiter
// Brief   : Independent round-robin read/write port arbitration of one
//           two-port RAM between two requesters, with read-after-write stall.
// Rev     : 1.0
// ============================================================================
module iob_ext_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int HAZARD_STALL = 1
) (
  input  wire logic             clk_i,
  input  wire logic             arst_n_i,
  input  wire logic             cke_i,
  iob_ext_mem_arbiter_if.slave  bus
);

  logic              w_rd0, w_rd1, w_wr0, w_wr1;
  logic              w_rd_req, w_rd_idx, w_rd_gnt, w_hazard;
  logic              w_wr_gnt, w_wr_idx;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;

  logic r_rd_ptr, r_wr_ptr, r_rd_pend, r_rd_owner;

  assign w_rd0 = cke_i & bus.r0_valid_i & (bus.r0_wstrb_i == '0);
  assign w_rd1 = cke_i & bus.r1_valid_i & (bus.r1_wstrb_i == '0);
  assign w_wr0 = cke_i & bus.r0_valid_i & (bus.r0_wstrb_i != '0);
  assign w_wr1 = cke_i & bus.r1_valid_i & (bus.r1_wstrb_i != '0);

  // With a single candidate the index is simply whether it is requester 1.
  assign w_rd_req = w_rd0 | w_rd1;
  assign w_rd_idx = (w_rd0 & w_rd1) ? r_rd_ptr : w_rd1;
  assign w_wr_gnt = w_wr0 | w_wr1;
  assign w_wr_idx = (w_wr0 & w_wr1) ? r_wr_ptr : w_wr1;

  assign w_rd_addr = w_rd_idx ? bus.r1_addr_i : bus.r0_addr_i;
  assign w_wr_addr = w_wr_idx ? bus.r1_addr_i : bus.r0_addr_i;

  // The RAM read port returns pre-write data, so a colliding read waits a cycle.
  assign w_hazard = (HAZARD_STALL != 0) && w_rd_req && w_wr_gnt && (w_rd_addr == w_wr_addr);
  assign w_rd_gnt = w_rd_req & ~w_hazard;

  always_comb begin
    bus.r0_ready_o       = (w_rd_gnt & ~w_rd_idx) | (w_wr_gnt & ~w_wr_idx);
    bus.r1_ready_o       = (w_rd_gnt &  w_rd_idx) | (w_wr_gnt &  w_wr_idx);

    bus.ext_mem_r_en_o   = w_rd_gnt;
    bus.ext_mem_r_addr_o = '0;
    if (w_rd_gnt) bus.ext_mem_r_addr_o = w_rd_addr;

    bus.ext_mem_w_strb_o = '0;
    bus.ext_mem_w_addr_o = '0;
    bus.ext_mem_w_data_o = '0;
    if (w_wr_gnt) begin
      bus.ext_mem_w_strb_o = w_wr_idx ? bus.r1_wstrb_i : bus.r0_wstrb_i;
      bus.ext_mem_w_addr_o = w_wr_addr;
      bus.ext_mem_w_data_o = w_wr_idx ? bus.r1_wdata_i : bus.r0_wdata_i;
    end

    bus.r0_rvalid_o = r_rd_pend & ~r_rd_owner;
    bus.r1_rvalid_o = r_rd_pend &  r_rd_owner;
    bus.r0_rdata_o  = '0;
    bus.r1_rdata_o  = '0;
    if (bus.r0_rvalid_o) bus.r0_rdata_o = bus.ext_mem_r_data_i;
    if (bus.r1_rvalid_o) bus.r1_rdata_o = bus.ext_mem_r_data_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else if (cke_i) begin
      r_rd_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_ptr   <= ~w_rd_idx;
        r_rd_owner <= w_rd_idx;
      end
      if (w_wr_gnt) r_wr_ptr <= ~w_wr_idx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_iob_ext_mem_arbiter
// Brief   : Directed bench with read/write scoreboards and a RAM model.
// Rev     : 1.0
// ============================================================================
module tb_iob_ext_mem_arbiter;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cke = 1'b1;
  always #5 clk = ~clk;

  iob_ext_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  iob_ext_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .HAZARD_STALL(1)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .cke_i    (cke),
    .bus      (bus.slave)
  );

  // Byte-strobed two-port RAM, one-cycle registered read
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    mem[8'h40] = 32'h11223344;
    bus.ext_mem_r_data_i = '0;
  end
  always @(posedge clk) begin
    if (bus.ext_mem_r_en_o) bus.ext_mem_r_data_i <= mem[bus.ext_mem_r_addr_o[7:0]];
    for (int b = 0; b < 4; b++)
      if (bus.ext_mem_w_strb_o[b]) mem[bus.ext_mem_w_addr_o[7:0]][8*b +: 8] <= bus.ext_mem_w_data_o[8*b +: 8];
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rd0[$];
  logic [31:0] exp_rd1[$];
  logic [51:0] exp_wr[$];   // {strb, addr, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares DUT read returns and RAM writes against the queues
  always @(negedge clk) begin
    if (bus.r0_rvalid_o) begin
      if (exp_rd0.size() == 0) chk("r0 unexpected rvalid", 1, 0);
      else chk("r0 rdata", bus.r0_rdata_o, exp_rd0.pop_front());
    end else chk("r0 rdata idle", bus.r0_rdata_o, 0);
    if (bus.r1_rvalid_o) begin
      if (exp_rd1.size() == 0) chk("r1 unexpected rvalid", 1, 0);
      else chk("r1 rdata", bus.r1_rdata_o, exp_rd1.pop_front());
    end else chk("r1 rdata idle", bus.r1_rdata_o, 0);
    if (bus.ext_mem_w_strb_o != '0) begin
      if (exp_wr.size() == 0) chk("unexpected write", 1, 0);
      else chk("write strb/addr/data",
               {bus.ext_mem_w_strb_o, bus.ext_mem_w_addr_o, bus.ext_mem_w_data_o}, exp_wr.pop_front());
    end
  end

  task automatic req(input int n, input logic v, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    if (n == 0) begin
      bus.r0_valid_i = v; bus.r0_addr_i = a; bus.r0_wdata_i = d; bus.r0_wstrb_i = s;
    end else begin
      bus.r1_valid_i = v; bus.r1_addr_i = a; bus.r1_wdata_i = d; bus.r1_wstrb_i = s;
    end
  endtask

  task automatic idle();
    req(0, 0, 0, 0, 0);
    req(1, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy(input string name, input logic e0, input logic e1);
    chk({name, " r0_ready"}, bus.r0_ready_o, e0);
    chk({name, " r1_ready"}, bus.r1_ready_o, e1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #2;
    chk("reset r0_rvalid", bus.r0_rvalid_o, 0);
    chk("reset r1_rvalid", bus.r1_rvalid_o, 0);
    chk("reset r_en", bus.ext_mem_r_en_o, 0);
    chk("reset w_strb", bus.ext_mem_w_strb_o, 0);
    tick(); tick();
    arst_n = 1'b1;
    tick();

    // 1: simultaneous reads, r0 preferred then r1
    req(0, 1, 16'h0004, 0, 0); req(1, 1, 16'h0008, 0, 0); #1;
    rdy("t1 c0", 1, 0);
    chk("t1 c0 r_addr", bus.ext_mem_r_addr_o, 16'h0004);
    exp_rd0.push_back(32'hC0DE0004);
    tick(); req(0, 0, 0, 0, 0); #1;
    rdy("t1 c1", 0, 1);
    chk("t1 c1 r0_rvalid", bus.r0_rvalid_o, 1);
    exp_rd1.push_back(32'hC0DE0008);
    tick(); req(1, 0, 0, 0, 0); #1;
    chk("t1 c2 r1_rvalid", bus.r1_rvalid_o, 1);
    // rd_ptr back at 0: r0 wins again
    req(0, 1, 16'h000C, 0, 0); req(1, 1, 16'h0014, 0, 0); #1;
    rdy("t1 ptr", 1, 0);
    exp_rd0.push_back(32'hC0DE000C);
    tick(); req(0, 0, 0, 0, 0); #1;
    rdy("t1 ptr r1", 0, 1);
    exp_rd1.push_back(32'hC0DE0014);
    tick(); idle(); tick();

    // 2: read of the address being written is stalled one cycle
    req(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF); req(1, 1, 16'h0010, 0, 0); #1;
    rdy("t2 c0", 1, 0);
    chk("t2 c0 r_en stalled", bus.ext_mem_r_en_o, 0);
    exp_wr.push_back({4'hF, 16'h0010, 32'hDEADBEEF});
    tick(); req(0, 0, 0, 0, 0); #1;
    rdy("t2 c1", 0, 1);
    exp_rd1.push_back(32'hDEADBEEF);
    tick(); idle(); tick();

    // 3: read and write of different requesters in the same cycle
    req(0, 1, 16'h0020, 0, 0); req(1, 1, 16'h0030, 32'h12345678, 4'hF); #1;
    rdy("t3", 1, 1);
    chk("t3 r_en", bus.ext_mem_r_en_o, 1);
    chk("t3 w_strb", bus.ext_mem_w_strb_o, 4'hF);
    exp_rd0.push_back(32'hC0DE0020);
    exp_wr.push_back({4'hF, 16'h0030, 32'h12345678});
    tick(); idle(); #1;
    chk("t3 r0_rvalid", bus.r0_rvalid_o, 1);
    tick();

    // 4: partial-byte write then read back
    req(1, 1, 16'h0040, 32'h0000AA00, 4'h2); #1;
    rdy("t4 write", 0, 1);
    exp_wr.push_back({4'h2, 16'h0040, 32'h0000AA00});
    tick(); req(1, 1, 16'h0040, 0, 0); #1;
    rdy("t4 read", 0, 1);
    exp_rd1.push_back(32'h1122AA44);
    tick(); idle(); tick();

    // 5: continuous writes alternate 0,1,0,1,0,1
    req(0, 1, 16'h0050, 32'hA0A0A0A0, 4'hF); req(1, 1, 16'h0060, 32'hB1B1B1B1, 4'hF);
    for (int c = 0; c < 6; c++) begin
      #1;
      rdy("t5 alternate", (c % 2) == 0, (c % 2) == 1);
      if (c % 2 == 0) exp_wr.push_back({4'hF, 16'h0050, 32'hA0A0A0A0});
      else            exp_wr.push_back({4'hF, 16'h0060, 32'hB1B1B1B1});
      tick();
    end
    idle();
    req(0, 1, 16'h0054, 32'h55555555, 4'hF); #1;   // leaves wr_ptr at 1
    exp_wr.push_back({4'hF, 16'h0054, 32'h55555555});
    tick(); idle();
    req(1, 1, 16'h0004, 0, 0); #1;
    rdy("t5 r1 read", 0, 1);
    tick(); idle();
    #1 arst_n = 1'b0;
    #1 chk("t5 reset kills rvalid", bus.r1_rvalid_o, 0);
    tick(); arst_n = 1'b1;
    tick();
    chk("t5 no late rvalid", bus.r1_rvalid_o, 0);
    req(0, 1, 16'h0058, 32'h58585858, 4'hF); req(1, 1, 16'h005C, 32'h5C5C5C5C, 4'hF); #1;
    rdy("t5 wr_ptr reset", 1, 0);
    exp_wr.push_back({4'hF, 16'h0058, 32'h58585858});
    tick(); req(0, 0, 0, 0, 0); #1;
    exp_wr.push_back({4'hF, 16'h005C, 32'h5C5C5C5C});
    tick(); idle();
    req(0, 1, 16'h0008, 0, 0); req(1, 1, 16'h000C, 0, 0); #1;
    rdy("t5 rd_ptr reset", 1, 0);
    exp_rd0.push_back(32'hC0DE0008);
    tick(); req(0, 0, 0, 0, 0); #1;
    exp_rd1.push_back(32'hC0DE000C);
    tick(); idle(); tick();

    // 6: clock enable low freezes arbitration
    req(0, 1, 16'h0070, 32'h70707070, 4'hF); #1;   // leaves wr_ptr at 1
    exp_wr.push_back({4'hF, 16'h0070, 32'h70707070});
    tick(); idle(); tick();
    cke = 1'b0;
    req(0, 1, 16'h0074, 32'h74747474, 4'hF); req(1, 1, 16'h0078, 32'h78787878, 4'hF);
    for (int c = 0; c < 3; c++) begin
      #1;
      rdy("t6 frozen", 0, 0);
      chk("t6 frozen r_en", bus.ext_mem_r_en_o, 0);
      chk("t6 frozen w_strb", bus.ext_mem_w_strb_o, 0);
      tick();
    end
    cke = 1'b1; #1;
    rdy("t6 resume", 0, 1);
    exp_wr.push_back({4'hF, 16'h0078, 32'h78787878});
    tick(); req(1, 0, 0, 0, 0); #1;
    rdy("t6 resume next", 1, 0);
    exp_wr.push_back({4'hF, 16'h0074, 32'h74747474});
    tick(); idle();
    tick(); tick(); tick();

    chk("queues drained", exp_rd0.size() + exp_rd1.size() + exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
